// File: rtl/layer_sequencer_pkg.sv
// ============================================================================
// layer_sequencer_pkg : shared state encoding and cfg beat type codes
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package layer_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    localparam logic CFG_WEIGHT = 1'b0;
    localparam logic CFG_BIAS   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/layer_sequencer_result_buffer.sv
// ============================================================================
// result_buffer : per-neuron result capture with indexed serialising read
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module result_buffer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_W       = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_ENTRIES-1:0]            wr_en,
    input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]                  rd_idx,
    output logic [DATA_WIDTH-1:0]             rd_data
);

    logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];

    // Each entry has its own enable so simultaneous neuron results all land.
    for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mem[k] <= '0;
            end else if (wr_en[k]) begin
                mem[k] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// layer_sequencer : loads neuron weights/biases, streams activations to a
//                   neuron layer, gathers its results and serialises them out
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_INPUTS    = 784,
    parameter int NUM_NEURONS   = 30,
    parameter int DATA_WIDTH    = 16,
    parameter int LAYER_NO      = 1,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic                              cfg_is_bias,
    input  logic [31:0]                       cfg_neuron,
    input  logic [31:0]                       cfg_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic [DATA_WIDTH-1:0]             neuron_in,
    output logic                              neuron_in_valid,
    output logic                              weightValid,
    output logic                              biasValid,
    output logic [31:0]                       weightValue,
    output logic [31:0]                       biasValue,
    output logic [31:0]                       config_layer_num,
    output logic [31:0]                       config_neuron_num,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_outvalid,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              busy,
    output logic                              err
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    state_t                 state, next_state;
    logic [CNT_W-1:0]       beat_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [IDX_W-1:0]       out_idx;
    logic [NUM_NEURONS-1:0] done_mask, merged_mask, cap_we;
    logic                   cfg_fire, s_fire, m_fire, drain_tmo;
    logic                   last_beat, last_out;

    assign last_beat = (beat_cnt == CNT_W'(NUM_INPUTS - 1));
    assign last_out  = (out_idx == IDX_W'(NUM_NEURONS - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Ready outputs in IDLE are gated by rst so every output reads 0 in reset.
    always_comb begin
        next_state  = state;
        cfg_ready   = 1'b0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        cfg_fire    = 1'b0;
        s_fire      = 1'b0;
        m_fire      = 1'b0;
        drain_tmo   = 1'b0;
        cap_we      = '0;
        merged_mask = done_mask;
        case (state)
            IDLE: begin
                cfg_ready = rst;
                s_ready   = rst & ~cfg_valid;
                cfg_fire  = cfg_valid & rst;
                s_fire    = s_valid & rst & ~cfg_valid;
                if (s_fire) next_state = last_beat ? DRAIN : STREAM;
            end
            STREAM: begin
                s_ready = 1'b1;
                s_fire  = s_valid;
                if (s_fire && last_beat) next_state = DRAIN;
            end
            DRAIN: begin
                cap_we      = neuron_outvalid;
                merged_mask = done_mask | neuron_outvalid;
                if (&merged_mask) begin
                    next_state = OUTPUT;
                end else if (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1)) begin
                    drain_tmo  = 1'b1;
                    next_state = IDLE;
                end
            end
            OUTPUT: begin
                m_valid = 1'b1;
                m_fire  = m_ready;
                if (m_ready && last_out) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt          <= '0;
            tmo_cnt           <= '0;
            out_idx           <= '0;
            done_mask         <= '0;
            err               <= 1'b0;
            neuron_in         <= '0;
            neuron_in_valid   <= 1'b0;
            weightValid       <= 1'b0;
            biasValid         <= 1'b0;
            weightValue       <= '0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
        end else begin
            weightValid     <= cfg_fire & (cfg_is_bias == CFG_WEIGHT);
            biasValid       <= cfg_fire & (cfg_is_bias == CFG_BIAS);
            neuron_in_valid <= s_fire;
            if (cfg_fire) begin
                if (cfg_is_bias == CFG_BIAS) biasValue   <= cfg_data;
                else                         weightValue <= cfg_data;
                config_neuron_num <= cfg_neuron;
                config_layer_num  <= 32'(LAYER_NO);
            end
            if (s_fire) begin
                neuron_in <= s_data;
                beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (state == DRAIN) begin
                if (next_state != DRAIN) begin
                    done_mask <= '0;
                    tmo_cnt   <= '0;
                end else begin
                    done_mask <= merged_mask;
                    tmo_cnt   <= tmo_cnt + 1'b1;
                end
            end
            if (drain_tmo) err <= 1'b1;
            if (m_fire) out_idx <= last_out ? '0 : out_idx + 1'b1;
        end
    end

    result_buffer #(
        .NUM_ENTRIES (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_result_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_we),
        .wr_data (neuron_out),
        .rd_idx  (out_idx),
        .rd_data (m_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// tb_layer_sequencer : directed bench with a transaction-level reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    localparam int NI  = 4;
    localparam int NN  = 3;
    localparam int DW  = 16;
    localparam int TMO = 8;

    localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_OUT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_valid = 1'b0, cfg_ready, cfg_is_bias = 1'b0;
    logic [31:0]     cfg_neuron = '0, cfg_data = '0;
    logic            s_valid = 1'b0, s_ready;
    logic [DW-1:0]   s_data = '0;
    logic [DW-1:0]   neuron_in;
    logic            neuron_in_valid;
    logic            weightValid, biasValid;
    logic [31:0]     weightValue, biasValue, config_layer_num, config_neuron_num;
    logic [NN*DW-1:0] neuron_out = '0;
    logic [NN-1:0]   neuron_outvalid = '0;
    logic            m_valid, m_ready = 1'b0;
    logic [DW-1:0]   m_data;
    logic            busy, err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW),
        .LAYER_NO(1), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_bias(cfg_is_bias),
        .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
        .weightValid(weightValid), .biasValid(biasValid),
        .weightValue(weightValue), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, beat/drain counts, captured results, one-shot expectations
    int            phase = P_IDLE, beats = 0, dcyc = 0, out_pos = 0;
    bit            got [NN];
    logic [DW-1:0] res [NN];
    bit            e_err = 0, e_wv = 0, e_bv = 0, e_niv = 0;
    logic [31:0]   e_wval, e_bval, e_neu;
    logic [DW-1:0] e_ni;
    logic [DW-1:0] seen_ni [$];
    logic [DW-1:0] seen_m  [$];
    int            mv_count = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase = P_IDLE; beats = 0; dcyc = 0; out_pos = 0;
                e_err = 0; e_wv = 0; e_bv = 0; e_niv = 0;
                for (int k = 0; k < NN; k++) begin got[k] = 0; res[k] = '0; end
                check("rst_ctrl", {56'd0, cfg_ready, s_ready, neuron_in_valid, weightValid,
                                   biasValid, m_valid, busy, err}, 64'd0);
                check("rst_data", {32'd0, neuron_in, m_data}, 64'd0);
                check("rst_cfg", {63'd0, |{weightValue, biasValue, config_layer_num,
                                          config_neuron_num}}, 64'd0);
            end else begin
                // compare current DUT outputs against the model's view of this cycle
                check("cfg_ready", cfg_ready, phase == P_IDLE);
                check("s_ready", s_ready, (phase == P_IDLE && !cfg_valid) || phase == P_STREAM);
                check("busy", busy, phase != P_IDLE);
                check("m_valid", m_valid, phase == P_OUT);
                if (phase == P_OUT) check("m_data", m_data, res[out_pos]);
                check("err", err, e_err);
                check("nin_valid", neuron_in_valid, e_niv);
                if (e_niv) check("nin_data", neuron_in, e_ni);
                check("weightValid", weightValid, e_wv);
                check("biasValid", biasValid, e_bv);
                if (e_wv) check("weightValue", weightValue, e_wval);
                if (e_bv) check("biasValue", biasValue, e_bval);
                if (e_wv || e_bv) begin
                    check("cfg_neuron_num", config_neuron_num, e_neu);
                    check("cfg_layer_num", config_layer_num, 1);
                end
                if (neuron_in_valid) seen_ni.push_back(neuron_in);
                if (m_valid) mv_count++;
                if (m_valid && m_ready) seen_m.push_back(m_data);

                // advance the model with the inputs the next rising edge will see
                e_wv = 0; e_bv = 0; e_niv = 0;
                case (phase)
                    P_IDLE, P_STREAM: begin
                        if (phase == P_IDLE && cfg_valid) begin
                            if (cfg_is_bias) begin e_bv = 1; e_bval = cfg_data; end
                            else             begin e_wv = 1; e_wval = cfg_data; end
                            e_neu = cfg_neuron;
                        end else if (s_valid) begin
                            e_niv = 1; e_ni = s_data; beats++;
                            if (beats == NI) begin phase = P_DRAIN; beats = 0; dcyc = 0; end
                            else phase = P_STREAM;
                        end
                    end
                    P_DRAIN: begin
                        bit all;
                        dcyc++;
                        all = 1;
                        for (int k = 0; k < NN; k++) begin
                            if (neuron_outvalid[k]) begin
                                res[k] = neuron_out[k*DW +: DW];
                                got[k] = 1;
                            end
                            all &= got[k];
                        end
                        if (all || dcyc == TMO) begin
                            if (all) begin phase = P_OUT; out_pos = 0; end
                            else begin e_err = 1; phase = P_IDLE; end
                            for (int k = 0; k < NN; k++) got[k] = 0;
                        end
                    end
                    default: begin
                        if (m_ready) begin
                            out_pos++;
                            if (out_pos == NN) phase = P_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = DW'(first + i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain_out(input string tag);
        bit done;
        done = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
            else tick();
        end
        check({tag, "_finished"}, done, 1);
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // weight beat, then a bias beat that must win over a simultaneous stream beat
        cfg_valid = 1'b1; cfg_neuron = 32'd2; cfg_data = 32'h1234; cfg_is_bias = 1'b0;
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("lit_weightValid", weightValid, 1);
        check("lit_weightValue", weightValue, 32'h1234);
        check("lit_neuron_num", config_neuron_num, 2);
        check("lit_layer_num", config_layer_num, 1);
        tick();
        cfg_valid = 1'b1; cfg_neuron = 32'd0; cfg_data = 32'hBEEF; cfg_is_bias = 1'b1;
        s_valid = 1'b1; s_data = 16'h77;
        @(negedge clk);
        check("lit_prio_s_ready", s_ready, 0);
        tick();
        cfg_valid = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("lit_biasValid", biasValid, 1);
        check("lit_biasValue", biasValue, 32'hBEEF);
        check("lit_no_beat", neuron_in_valid, 0);
        tick();

        // gapped stream with stray outvalid pulses that must be ignored
        seen_ni.delete();
        for (int i = 0; i < NI; i++) begin
            s_valid = 1'b1; s_data = DW'(5 + i);
            tick();
            s_valid = 1'b0;
            if (i == 0) begin
                neuron_out = {16'd99, 16'd99, 16'd99}; neuron_outvalid = 3'b111;
            end
            tick();
            neuron_outvalid = 3'b000;
            if (i % 2 == 1) tick();
        end
        @(negedge clk);
        check("lit_drain_s_ready", s_ready, 0);
        check("lit_nin_count", seen_ni.size(), 4);
        for (int i = 0; i < 4; i++) check("lit_nin_seq", seen_ni[i], 5 + i);

        // partial then completing drain pulses, then backpressure on the output
        tick();
        neuron_out = {16'd30, 16'd20, 16'd10}; neuron_outvalid = 3'b011;
        tick();
        neuron_outvalid = 3'b100;
        tick();
        neuron_outvalid = 3'b000;
        seen_m.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lit_bp_valid", m_valid, 1);
            check("lit_bp_data", m_data, 10);
            tick();
        end
        drain_out("out1");
        check("lit_m_valid_drop", m_valid, 0);
        check("lit_m_count", seen_m.size(), 3);
        for (int i = 0; i < 3; i++) check("lit_m_seq", seen_m[i], 10 * (i + 1));
        tick();

        // timeout: only neuron 0 ever answers
        mv_count = 0;
        send_beats(1, NI);
        neuron_out = {16'd0, 16'd0, 16'd42}; neuron_outvalid = 3'b001;
        repeat (12) tick();
        neuron_outvalid = 3'b000;
        @(negedge clk);
        check("lit_tmo_err", err, 1);
        check("lit_tmo_busy", busy, 0);
        check("lit_tmo_no_mvalid", mv_count, 0);
        tick();

        // reset mid-stream, then a clean run
        send_beats(1, 2);
        rst = 1'b0;
        @(negedge clk);
        check("lit_abort_busy", busy, 0);
        check("lit_abort_err", err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        seen_ni.delete();
        seen_m.delete();
        send_beats(11, NI);
        neuron_out = {16'd3, 16'd2, 16'd1}; neuron_outvalid = 3'b111;
        tick();
        neuron_outvalid = 3'b000;
        drain_out("out2");
        check("lit_fresh_nin_count", seen_ni.size(), 4);
        check("lit_fresh_nin_last", seen_ni[3], 14);
        check("lit_fresh_m_count", seen_m.size(), 3);
        for (int i = 0; i < 3; i++) check("lit_fresh_m_seq", seen_m[i], i + 1);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
